// File: rtl/bp_mem_block_responder.sv
// rtl/bp_mem_block_responder.sv - single-outstanding cce_mem_msg responder backed by block storage
// Message layout, LSB first: msg_type[3:0], addr, size[2:0], way_id, lce_id, data.
module bp_mem_block_responder #(
  parameter int paddr_width_p       = 40,
  parameter int cce_block_width_p   = 512,
  parameter int lce_id_width_p      = 4,
  parameter int icache_lce_assoc_p  = 8,
  parameter int mem_els_p           = 1024,
  parameter logic [paddr_width_p-1:0] mem_offset_p = '0,
  parameter int latency_p           = 4,
  localparam int way_id_width_lp    = $clog2(icache_lce_assoc_p),
  localparam int cce_mem_msg_width_lp = 4 + paddr_width_p + 3 + way_id_width_lp
                                        + lce_id_width_p + cce_block_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                            mem_cmd_v_i,
  output logic                            mem_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
  output logic                            mem_resp_v_o,
  input  logic                            mem_resp_yumi_i
);

  localparam int hdr_width_lp = cce_mem_msg_width_lp - cce_block_width_p;
  localparam int off_width_lp = $clog2(cce_block_width_p / 8);
  localparam int idx_width_lp = $clog2(mem_els_p);
  localparam int cnt_width_lp = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

  localparam logic [3:0] e_cce_mem_rd    = 4'd0;
  localparam logic [3:0] e_cce_mem_wr    = 4'd1;
  localparam logic [3:0] e_cce_mem_uc_rd = 4'd2;
  localparam logic [3:0] e_cce_mem_uc_wr = 4'd3;
  localparam logic [3:0] e_cce_mem_wb    = 4'd4;

  typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

  state_e                          state_q, state_d;
  logic [cnt_width_lp-1:0]         cnt_q, cnt_d;
  logic [cce_mem_msg_width_lp-1:0] cmd_q, cmd_d;
  logic [cce_mem_msg_width_lp-1:0] resp_q, resp_d;
  logic [cce_block_width_p-1:0]    mem_r [mem_els_p];

  logic [3:0]                   cmd_type;
  logic [paddr_width_p-1:0]     cmd_addr;
  logic [2:0]                   cmd_size;
  logic [cce_block_width_p-1:0] cmd_data;
  logic [paddr_width_p-1:0]     blk_num;
  logic [idx_width_lp-1:0]      idx;
  logic [1:0]                   uc_lg;
  logic [3:0]                   uc_bytes;
  logic [63:0]                  bmask64;
  logic [off_width_lp-1:0]      uc_off;
  logic [off_width_lp+2:0]      bit_off;
  logic [cce_block_width_p-1:0] rd_blk, wr_blk, blk_bmask, acc_rdata;
  logic                         wr_op;
  logic                         mem_we;

  assign cmd_type = cmd_q[3:0];
  assign cmd_addr = cmd_q[4 +: paddr_width_p];
  assign cmd_size = cmd_q[4 + paddr_width_p +: 3];
  assign cmd_data = cmd_q[hdr_width_lp +: cce_block_width_p];

  // Uncached sizes saturate at 8 bytes; the offset is forced to natural alignment.
  always_comb begin
    blk_num   = (cmd_addr - mem_offset_p) >> off_width_lp;
    idx       = idx_width_lp'(blk_num % paddr_width_p'(mem_els_p));
    uc_lg     = cmd_size[2] ? 2'd3 : cmd_size[1:0];
    uc_bytes  = 4'd1 << uc_lg;
    bmask64   = (uc_lg == 2'd3) ? '1 : ((64'd1 << {uc_bytes, 3'b000}) - 64'd1);
    uc_off    = cmd_addr[off_width_lp-1:0] & ~(off_width_lp'(uc_bytes) - off_width_lp'(1));
    bit_off   = {uc_off, 3'b000};
    rd_blk    = mem_r[idx];
    blk_bmask = cce_block_width_p'(bmask64) << bit_off;
    wr_blk    = rd_blk;
    acc_rdata = '0;
    wr_op     = 1'b0;
    case (cmd_type)
      e_cce_mem_rd, e_cce_mem_wr: acc_rdata = rd_blk;
      e_cce_mem_wb: begin
        wr_blk = cmd_data;
        wr_op  = 1'b1;
      end
      e_cce_mem_uc_rd: acc_rdata = cce_block_width_p'(64'(rd_blk >> bit_off) & bmask64);
      e_cce_mem_uc_wr: begin
        wr_blk = (rd_blk & ~blk_bmask)
               | ((cce_block_width_p'(cmd_data[63:0]) << bit_off) & blk_bmask);
        wr_op  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    resp_d  = resp_q;
    mem_we  = 1'b0;
    case (state_q)
      e_ready: begin
        if (mem_cmd_v_i) begin
          cmd_d   = mem_cmd_i;
          cnt_d   = cnt_width_lp'(latency_p);
          state_d = e_wait;
        end
      end
      e_wait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - cnt_width_lp'(1);
        end else begin
          resp_d  = {acc_rdata, cmd_q[hdr_width_lp-1:0]};
          mem_we  = wr_op;
          state_d = e_resp;
        end
      end
      e_resp: begin
        if (mem_resp_yumi_i) state_d = e_ready;
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_ready;
      cnt_q   <= '0;
      cmd_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      resp_q  <= resp_d;
    end
  end

  // Storage is deliberately not reset so contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_r[idx] <= wr_blk;
  end

  assign mem_cmd_ready_o = reset_n_i & (state_q == e_ready);
  assign mem_resp_v_o    = (state_q == e_resp);
  assign mem_resp_o      = resp_q;

endmodule

// File: tb/tb_bp_mem_block_responder.sv
// tb/tb_bp_mem_block_responder.sv - randomized self-checking bench with behavioural storage model
module tb_bp_mem_block_responder;

  localparam int PADDR = 40;
  localparam int BLK   = 512;
  localparam int LCE_W = 4;
  localparam int WAY_W = 3;
  localparam int W     = 4 + PADDR + 3 + WAY_W + LCE_W + BLK;
  localparam int DLSB  = W - BLK;
  localparam int LAT   = 4;
  localparam logic [3:0] RD = 4'd0, WR = 4'd1, UCRD = 4'd2, UCWR = 4'd3, WB = 4'd4, OTHER = 4'd5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] cmd, resp, cmd0, resp0;
  logic         cmd_v, rdy, resp_v, yumi;
  logic         cmd0_v, rdy0, resp0_v, yumi0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [511:0] mdl [int];
  logic [W-1:0] last_resp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bp_mem_block_responder #(
    .paddr_width_p(PADDR), .cce_block_width_p(BLK), .lce_id_width_p(LCE_W),
    .icache_lce_assoc_p(8), .mem_els_p(1024), .mem_offset_p(40'h0), .latency_p(LAT)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .mem_cmd_i(cmd), .mem_cmd_v_i(cmd_v),
    .mem_cmd_ready_o(rdy), .mem_resp_o(resp), .mem_resp_v_o(resp_v), .mem_resp_yumi_i(yumi)
  );

  bp_mem_block_responder #(
    .paddr_width_p(PADDR), .cce_block_width_p(BLK), .lce_id_width_p(LCE_W),
    .icache_lce_assoc_p(8), .mem_els_p(1024), .mem_offset_p(40'h0), .latency_p(0)
  ) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .mem_cmd_i(cmd0), .mem_cmd_v_i(cmd0_v),
    .mem_cmd_ready_o(rdy0), .mem_resp_o(resp0), .mem_resp_v_o(resp0_v), .mem_resp_yumi_i(yumi0)
  );

  task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [3:0] t, input logic [39:0] a,
                                        input logic [2:0] s, input logic [3:0] lce,
                                        input logic [2:0] way, input logic [511:0] d);
    return {d, lce, way, s, a, t};
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Reference: byte-granular view of each block, keyed by wrapped block number.
  function automatic logic [W-1:0] model(input logic [3:0] t, input logic [39:0] a,
                                         input logic [2:0] s, input logic [3:0] lce,
                                         input logic [2:0] way, input logic [511:0] d);
    int idx, nb, off;
    logic [511:0] blk, rd;
    idx = int'((a / 40'd64) % 40'd1024);
    nb  = 1 << ((s > 3'd3) ? 3 : int'(s));
    off = (int'(a % 40'd64) / nb) * nb;
    blk = mdl.exists(idx) ? mdl[idx] : '0;
    rd  = '0;
    case (t)
      RD, WR: rd = blk;
      WB: mdl[idx] = d;
      UCRD: for (int b = 0; b < nb; b++) rd[8*b +: 8] = blk[8*(off+b) +: 8];
      UCWR: begin
        for (int b = 0; b < nb; b++) blk[8*(off+b) +: 8] = d[8*b +: 8];
        mdl[idx] = blk;
      end
      default: ;
    endcase
    return pack(t, a, s, lce, way, rd);
  endfunction

  task automatic do_txn(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                        input logic [3:0] lce, input logic [2:0] way, input logic [511:0] d,
                        input int hold);
    logic [W-1:0] exp;
    int c0, n;
    logic busy_ok, stable;
    exp = model(t, a, s, lce, way, d);
    @(negedge clk);
    n = 0;
    while (!rdy && n < 20) begin @(negedge clk); n++; end
    check("cmd_ready", rdy, 1);
    cmd = pack(t, a, s, lce, way, d);
    cmd_v = 1'b1;
    c0 = cyc;
    @(negedge clk);
    cmd_v = 1'b0;
    cmd = ~cmd;
    busy_ok = 1'b1;
    n = 0;
    while (!resp_v && n < 20) begin
      busy_ok &= !rdy;
      @(negedge clk);
      n++;
    end
    check("ready_low_wait", busy_ok, 1);
    check("resp_latency", cyc - c0, LAT + 2);
    check("resp", resp, exp);
    last_resp = resp;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      stable &= resp_v && !rdy && (resp === exp);
    end
    if (hold > 0) check("resp_hold", stable, 1);
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    check("resp_v_after_yumi", resp_v, 0);
    check("ready_after_yumi", rdy, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [511:0] p, q;
    logic [39:0] bases [6];
    logic [39:0] a;
    logic [3:0] t;
    logic [2:0] s;
    int acc, rsp, c;
    logic [15:0] acc_map, rsp_map;
    logic no_resp, hdr_ok;

    bases = '{40'h0, 40'h40, 40'h80, 40'hC0, 40'h100, 40'h140};
    rst_n = 1'b1; cmd = '0; cmd_v = 1'b0; yumi = 1'b0;
    cmd0 = '0; cmd0_v = 1'b0; yumi0 = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", rdy, 0);
    check("reset_resp_v", resp_v, 0);
    check("reset_resp", resp, 0);
    rst_n = 1'b1;
    #1 check("ready_after_reset", rdy, 1);

    for (int i = 0; i < 6; i++) do_txn(WB, bases[i], 3'd3, 4'd0, 3'd0, rnd512(), 0);

    do_txn(UCWR, 40'h80, 3'd3, 4'd2, 3'd1, 512'hDEADBEEF_CAFEF00D, 3);

    p = rnd512();
    do_txn(WB, 40'h40, 3'd3, 4'd0, 3'd0, p, 0);
    do_txn(RD, 40'h40, 3'd3, 4'd1, 3'd3, '0, 0);
    check("rd_after_wb_data", last_resp[DLSB +: BLK], p);
    do_txn(WR, 40'h40, 3'd3, 4'd1, 3'd3, '0, 1);
    check("wr_fill_data", last_resp[DLSB +: BLK], p);

    do_txn(UCWR, 40'h44, 3'd0, 4'd0, 3'd0, 512'hAB, 0);
    do_txn(UCRD, 40'h44, 3'd0, 4'd0, 3'd0, '0, 0);
    check("uc_rd_byte", last_resp[DLSB +: BLK], 512'hAB);
    do_txn(UCRD, 40'h40, 3'd3, 4'd0, 3'd0, '0, 0);
    check("uc_rd_byte4", last_resp[DLSB + 32 +: 8], 8'hAB);
    do_txn(UCRD, 40'h43, 3'd2, 4'd0, 3'd0, '0, 0);
    do_txn(RD, 40'h10040, 3'd3, 4'd0, 3'd0, '0, 0);
    do_txn(OTHER, 40'h40, 3'd3, 4'd0, 3'd0, rnd512(), 0);
    do_txn(RD, 40'h40, 3'd3, 4'd0, 3'd0, '0, 0);

    // latency 0 instance: valid and yumi held high continuously
    @(negedge clk);
    cmd0 = pack(WB, 40'h200, 3'd3, 4'd5, 3'd6, p);
    cmd0_v = 1'b1; yumi0 = 1'b1;
    acc = 0; rsp = 0; acc_map = '0; rsp_map = '0; hdr_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (rdy0) begin acc++; acc_map[k] = 1'b1; end
      if (resp0_v) begin
        rsp++; rsp_map[k] = 1'b1;
        hdr_ok &= (resp0 === pack(WB, 40'h200, 3'd3, 4'd5, 3'd6, '0));
      end
      @(negedge clk);
    end
    cmd0_v = 1'b0; yumi0 = 1'b0;
    check("b2b_accepts", acc, 4);
    check("b2b_resps", rsp, 4);
    check("b2b_accept_cycles", acc_map, 16'h0249);
    check("b2b_resp_cycles", rsp_map, 16'h0924);
    check("b2b_resp_msg", hdr_ok, 1);

    // reset during the wait phase of a writeback
    q = rnd512();
    @(negedge clk);
    c = 0;
    while (!rdy && c < 20) begin @(negedge clk); c++; end
    check("abort_cmd_ready", rdy, 1);
    cmd = pack(WB, 40'h100, 3'd3, 4'd0, 3'd0, q);
    cmd_v = 1'b1;
    @(negedge clk);
    cmd_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("abort_ready_in_reset", rdy, 0);
    check("abort_resp_v_in_reset", resp_v, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("abort_ready_release", rdy, 1);
    no_resp = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      no_resp &= !resp_v;
    end
    check("abort_no_resp", no_resp, 1);
    do_txn(RD, 40'h100, 3'd3, 4'd0, 3'd0, '0, 0);

    for (int i = 0; i < 60; i++) begin
      t = 4'($urandom_range(0, 5));
      a = bases[$urandom_range(0, 5)] + 40'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a + 40'(1024 * 64);
      s = 3'($urandom_range(0, 3));
      do_txn(t, a, s, 4'($urandom), 3'($urandom), rnd512(), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
